// File: rtl/comparator_seq_ctrl.sv
// comparator_seq_ctrl: sequential 8-bit magnitude comparator.
// Compares one 3-bit slice per cycle (LSB slice first) and carries the running
// lt/eq/gt result between slices; the final result is held until the next DONE.
// Optional build macro: COMPARATOR_SEQ_SIGNED_EN (two's complement operands).
module comparator_seq_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       l,
    input  logic       e,
    input  logic       g,
    output logic       busy,
    output logic       done,
    output logic       lt,
    output logic       eq,
    output logic       gt
);

    localparam int unsigned OP_W    = 8;
    localparam int unsigned SLICE_W = 3;
    localparam int unsigned RES_W   = 3;

    // Carry/result encoding is {lt, eq, gt}
    localparam logic [RES_W-1:0] RES_LT = 3'b100;
    localparam logic [RES_W-1:0] RES_GT = 3'b001;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S0   = 3'd1,
        S1   = 3'd2,
        S2   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [OP_W-1:0]    a_q;
    logic [OP_W-1:0]    b_q;
    logic [RES_W-1:0]   carry_q;
    logic [RES_W-1:0]   carry_d;
    logic               cap_en;
    logic               res_en;
    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [RES_W-1:0]   slice_res;
    logic               a_msb;
    logic               b_msb;

`ifdef COMPARATOR_SEQ_SIGNED_EN
    // Flipping the sign bit maps two's complement order onto unsigned order
    assign a_msb = ~a_q[7];
    assign b_msb = ~b_q[7];
`else
    assign a_msb = a_q[7];
    assign b_msb = b_q[7];
`endif

    // Select the operand slice for the current compare step
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        case (state_q)
            S0: begin
                slice_a = a_q[2:0];
                slice_b = b_q[2:0];
            end
            S1: begin
                slice_a = a_q[5:3];
                slice_b = b_q[5:3];
            end
            S2: begin
                slice_a = {1'b0, a_msb, a_q[6]};
                slice_b = {1'b0, b_msb, b_q[6]};
            end
            default: begin
                slice_a = '0;
                slice_b = '0;
            end
        endcase
    end

    // Slice compare: an unequal higher slice overrides the carried result
    always_comb begin
        slice_res = carry_q;
        if (slice_a > slice_b) begin
            slice_res = RES_GT;
        end else if (slice_a < slice_b) begin
            slice_res = RES_LT;
        end
    end

    // Next-state, carry update and capture/result enables
    always_comb begin
        state_d = state_q;
        carry_d = carry_q;
        cap_en  = 1'b0;
        res_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = S0;
                    cap_en  = 1'b1;
                    carry_d = {l, e, g};
                end
            end
            S0: begin
                state_d = S1;
                carry_d = slice_res;
            end
            S1: begin
                state_d = S2;
                carry_d = slice_res;
            end
            S2: begin
                state_d = DONE;
                carry_d = slice_res;
                res_en  = 1'b1;
            end
            DONE: begin
                if (start) begin
                    state_d = S0;
                    cap_en  = 1'b1;
                    carry_d = {l, e, g};
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, operand, carry and registered output flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            a_q            <= '0;
            b_q            <= '0;
            carry_q        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            {lt, eq, gt}   <= '0;
        end else begin
            state_q <= state_d;
            carry_q <= carry_d;
            if (cap_en) begin
                a_q <= a;
                b_q <= b;
            end
            if (res_en) begin
                {lt, eq, gt} <= slice_res;
            end
            busy <= (state_d == S0) || (state_d == S1) || (state_d == S2);
            done <= (state_d == DONE);
        end
    end

endmodule
